// File: rtl/chip7458_pkg.sv
// rtl/chip7458_pkg.sv - shared types, sizes and reference function for the 7458 exerciser
package chip7458_pkg;

    localparam int VEC_W   = 10;
    localparam int NUM_VEC = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Expected {p2y, p1y} for a 10-bit input vector laid out as {p2d..p2a, p1f..p1a}
    function automatic logic [1:0] golden_7458(input logic [VEC_W-1:0] vec);
        logic exp1;
        logic exp2;
        exp1 = (&vec[2:0]) | (&vec[5:3]);
        exp2 = (&vec[7:6]) | (&vec[9:8]);
        return {exp2, exp1};
    endfunction

endpackage

// File: rtl/chip7458.sv
// rtl/chip7458.sv - 7458 dual AND-OR gate, used as the exerciser's golden model
module chip7458
    import chip7458_pkg::*;
(
    input  logic p1a,
    input  logic p1b,
    input  logic p1c,
    input  logic p1d,
    input  logic p1e,
    input  logic p1f,
    input  logic p2a,
    input  logic p2b,
    input  logic p2c,
    input  logic p2d,
    output logic p1y,
    output logic p2y
);

    // Section 1: two 3-input ANDs ORed; section 2: two 2-input ANDs ORed
    assign p1y = (p1a & p1b & p1c) | (p1d & p1e & p1f);
    assign p2y = (p2a & p2b) | (p2c & p2d);

endmodule

// File: rtl/chip7458_exerciser.sv
// rtl/chip7458_exerciser.sv - sweeps all 1024 vectors into a 7458 and checks its outputs
module chip7458_exerciser
    import chip7458_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 11,
    parameter int STOP_ON_FAIL  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             p1a,
    output logic             p1b,
    output logic             p1c,
    output logic             p1d,
    output logic             p1e,
    output logic             p1f,
    output logic             p2a,
    output logic             p2b,
    output logic             p2c,
    output logic             p2d,
    input  logic             p1y,
    input  logic             p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [VEC_W-1:0]  vec;
    logic [VEC_W-1:0]  pins;
    logic [CNT_W-1:0]  settle_cnt;

    logic              exp1;
    logic              exp2;
    logic              mismatch;
    logic              last_vec;
    logic              end_run;
    logic [ERR_W-1:0]  err_next;

    // Golden model evaluates the vector currently being presented
    chip7458 u_golden (
        .p1a (vec[0]),
        .p1b (vec[1]),
        .p1c (vec[2]),
        .p1d (vec[3]),
        .p1e (vec[4]),
        .p1f (vec[5]),
        .p2a (vec[6]),
        .p2b (vec[7]),
        .p2c (vec[8]),
        .p2d (vec[9]),
        .p1y (exp1),
        .p2y (exp2)
    );

    // Pin drives come straight from a register so the device sees no glitches
    assign p1a = pins[0];
    assign p1b = pins[1];
    assign p1c = pins[2];
    assign p1d = pins[3];
    assign p1e = pins[4];
    assign p1f = pins[5];
    assign p2a = pins[6];
    assign p2b = pins[7];
    assign p2c = pins[8];
    assign p2d = pins[9];

    // Compare the device against the golden model and work out the next error count
    always_comb begin
        mismatch = (p1y != exp1) | (p2y != exp2);
        last_vec = (vec == {VEC_W{1'b1}});
        end_run  = last_vec | ((STOP_ON_FAIL != 0) & mismatch);
        err_next = err_count;
        if (mismatch && (err_count != {ERR_W{1'b1}})) begin
            err_next = err_count + ERR_W'(1);
        end
    end

    // Run sequencer: IDLE -> (DRIVE -> CHECK) x 1024 -> DONE, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            vec            <= '0;
            pins           <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec            <= '0;
                        pins           <= '0;
                        settle_cnt     <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    // Count never wraps, so zero here means no earlier failure
                    if (mismatch && (err_count == '0)) begin
                        first_fail_vec <= vec;
                    end
                    if (end_run) begin
                        pins  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + VEC_W'(1);
                        pins  <= vec + VEC_W'(1);
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip7458_exerciser.sv
// tb/tb_chip7458_exerciser.sv - randomized fault-injection bench for chip7458_exerciser
module tb_chip7458_exerciser;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [3];
    logic [9:0] pv    [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [10:0] errc [3];
    logic [9:0] ffv   [3];

    int mode [3];
    bit c1 [1024];
    bit c2 [1024];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: stop on fail; 2: narrow counter, longer settle
    function automatic int s_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction
    function automatic int w_of(input int g);
        return (g == 2) ? 4 : 11;
    endfunction
    function automatic int stop_of(input int g);
        return (g == 1) ? 1 : 0;
    endfunction

    // Datasheet behaviour of a good 7458, written arithmetically
    function automatic logic [1:0] gold(input int v);
        logic y1;
        logic y2;
        y1 = ((v & 7) == 7) || (((v >> 3) & 7) == 7);
        y2 = (((v >> 6) & 3) == 3) || (((v >> 8) & 3) == 3);
        return {y2, y1};
    endfunction

    // Device under test as seen by the exerciser: good, stuck-at, or randomly corrupted
    function automatic logic [1:0] dev(input int v, input int m);
        logic [1:0] y;
        y = gold(v);
        case (m)
            1: y[0] = 1'b0;
            2: y[1] = 1'b1;
            3: y = y ^ {c2[v], c1[v]};
            default: ;
        endcase
        return y;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 2) ? 4 : 11;
        logic a, b, c, d, e, f, pa, pb, pc, pd, y1, y2;
        logic [W-1:0] ec;

        chip7458_exerciser #(
            .SETTLE_CYCLES ((g == 2) ? 3 : 1),
            .ERR_W         (W),
            .STOP_ON_FAIL  ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start[g]),
            .p1a            (a),
            .p1b            (b),
            .p1c            (c),
            .p1d            (d),
            .p1e            (e),
            .p1f            (f),
            .p2a            (pa),
            .p2b            (pb),
            .p2c            (pc),
            .p2d            (pd),
            .p1y            (y1),
            .p2y            (y2),
            .busy           (busy[g]),
            .done           (done[g]),
            .pass           (pass[g]),
            .err_count      (ec),
            .first_fail_vec (ffv[g])
        );

        assign pv[g]   = {pd, pc, pb, pa, f, e, d, c, b, a};
        assign errc[g] = 11'(ec);
        always_comb {y2, y1} = dev(int'(pv[g]), mode[g]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_tables(input int density);
        for (int i = 0; i < 1024; i++) begin
            c1[i] = ($urandom_range(0, density - 1) == 0);
            c2[i] = ($urandom_range(0, density - 1) == 0);
        end
    endtask

    // Expected outcome of one run, found by sweeping the whole truth table
    task automatic model(input int g, output int e_err, output int e_ffv,
                         output int e_cyc, output int e_pass);
        int cnt;
        int lim;
        cnt   = 0;
        e_ffv = 0;
        e_cyc = 1024 * (s_of(g) + 1);
        for (int v = 0; v < 1024; v++) begin
            if (dev(v, mode[g]) != gold(v)) begin
                if (cnt == 0) e_ffv = v;
                cnt++;
                if (stop_of(g) != 0) begin
                    e_cyc = (v + 1) * (s_of(g) + 1);
                    break;
                end
            end
        end
        lim    = (1 << w_of(g)) - 1;
        e_err  = (cnt > lim) ? lim : cnt;
        e_pass = (cnt == 0) ? 1 : 0;
    endtask

    // Pulse start, optionally poke start again mid-run, then check the results
    task automatic run(input int g, input int poke, input string tag);
        int k;
        int e_err, e_ffv, e_cyc, e_pass;
        model(g, e_err, e_ffv, e_cyc, e_pass);
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
        for (k = 1; k <= 20000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                chk({tag, " busy_early"}, 32'(busy[g]), 1);
                chk({tag, " done_drop"}, 32'(done[g]), 0);
                chk({tag, " vec0_pins"}, 32'(pv[g]), 0);
            end
            start[g] = (k == poke);
            if (done[g]) break;
        end
        start[g] = 1'b0;
        chk({tag, " done"}, 32'(done[g]), 1);
        chk({tag, " cycles"}, 32'(k), 32'(e_cyc));
        chk({tag, " pass"}, 32'(pass[g]), 32'(e_pass));
        chk({tag, " err_count"}, 32'(errc[g]), 32'(e_err));
        chk({tag, " first_fail_vec"}, 32'(ffv[g]), 32'(e_ffv));
        chk({tag, " busy_end"}, 32'(busy[g]), 0);
        chk({tag, " pins_end"}, 32'(pv[g]), 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            mode[g]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy[0]), 0);
        chk("reset done", 32'(done[0]), 0);
        chk("reset pass", 32'(pass[0]), 0);
        chk("reset err_count", 32'(errc[0]), 0);
        chk("reset first_fail_vec", 32'(ffv[0]), 0);
        chk("reset pins", 32'(pv[0]), 0);
        chk("reset pins narrow", 32'(pv[2]), 0);
        reset = 1'b0;

        run(0, -1, "good");
        chk("good err literal", 32'(errc[0]), 0);
        mode[0] = 1;
        run(0, -1, "p1y_sa0");
        chk("p1y_sa0 err literal", 32'(errc[0]), 240);
        chk("p1y_sa0 ffv literal", 32'(ffv[0]), 7);
        mode[0] = 2;
        run(0, -1, "p2y_sa1");
        chk("p2y_sa1 err literal", 32'(errc[0]), 576);
        mode[1] = 1;
        run(1, -1, "stop_p1y_sa0");
        mode[2] = 2;
        run(2, -1, "sat_p2y_sa1");
        chk("sat err literal", 32'(errc[2]), 15);

        mode[0] = 3;
        fill_tables(200);
        run(0, -1, "rand_sparse");
        fill_tables(8);
        run(0, -1, "rand_dense");
        mode[1] = 3;
        fill_tables(64);
        run(1, -1, "rand_stop");
        mode[2] = 3;
        fill_tables(40);
        run(2, -1, "rand_narrow");

        // Reset mid-run at vector 300 after errors have accumulated
        fill_tables(6);
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        for (n = 0; n < 5000 && pv[0] != 10'd300; n++) @(negedge clk);
        chk("reached vec300", 32'(pv[0]), 300);
        chk("busy at vec300", 32'(busy[0]), 1);
        @(negedge clk);
        reset    = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        start[0] = 1'b0;
        chk("midreset busy", 32'(busy[0]), 0);
        chk("midreset done", 32'(done[0]), 0);
        chk("midreset pins", 32'(pv[0]), 0);
        chk("midreset err_count", 32'(errc[0]), 0);
        chk("midreset first_fail_vec", 32'(ffv[0]), 0);
        @(posedge clk);
        #1;
        chk("midreset stays idle", 32'(busy[0]), 0);

        run(0, 700, "start_while_busy");
        run(0, -1, "rerun_from_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
